// File: rtl/counter_ctrl_pkg.sv
// ============================================================================
// Module   : counter_ctrl_pkg
// Brief    : Shared state encodings and default width for counter_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_ctrl_pkg;

    localparam int DEFAULT_N = 4;

    // Encoding is externally visible on the state port, so values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/load_counter.sv
// ============================================================================
// Module   : load_counter
// Brief    : N-bit register with parallel load, increment-enable and hold.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_counter
    import counter_ctrl_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clr,
    input  logic         clk,
    input  logic         load,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] Q
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    // Load wins over increment; natural N-bit overflow gives the wrap to 0.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            Q <= '0;
        end else if (load) begin
            Q <= d;
        end else if (en) begin
            Q <= Q + ONE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/counter_sequencer.sv
// ============================================================================
// Module   : counter_sequencer
// Brief    : Four-state count sequencer (IDLE/LOAD/RUN/HOLD) around load_counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_sequencer
    import counter_ctrl_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic         pause,
    input  logic         abort,
    input  logic         auto_reload,
    input  logic [N-1:0] load_val,
    input  logic [N-1:0] term_val,
    output logic [N-1:0] Q,
    output logic         busy,
    output logic         done,
    output logic [1:0]   state
);

    state_t state_q;
    state_t state_d;
    logic   done_d;
    logic   load_cnt;
    logic   inc_en;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
        end
    end

    // Priority inside each active state: abort, then pause, then terminal, then count.
    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        load_cnt = 1'b0;
        inc_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    load_cnt = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_HOLD;
                end else if (Q == term_val) begin
                    done_d  = 1'b1;
                    state_d = auto_reload ? ST_LOAD : ST_IDLE;
                end else begin
                    inc_en = 1'b1;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy  = (state_q != ST_IDLE);
    assign state = state_q;

    load_counter #(
        .N (N)
    ) u_counter (
        .clr  (clr),
        .clk  (clk),
        .load (load_cnt),
        .en   (inc_en),
        .d    (load_val),
        .Q    (Q)
    );

endmodule

`default_nettype wire

// File: tb/tb_counter_sequencer.sv
// ============================================================================
// Module   : tb_counter_sequencer
// Brief    : Directed and randomized bench for counter_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_sequencer;

    localparam int N = 4;
    localparam int M = 1 << N;

    logic         clk = 1'b0;
    logic         clr;
    logic         start;
    logic         pause;
    logic         abort;
    logic         auto_reload;
    logic [N-1:0] load_val;
    logic [N-1:0] term_val;
    logic [N-1:0] Q;
    logic         busy;
    logic         done;
    logic [1:0]   state;

    int tests      = 0;
    int fails      = 0;
    int done_count = 0;

    // Reference: 0=idle 1=load 2=run 3=hold, count kept as a plain integer.
    int m_state;
    int m_q;
    int m_done;

    counter_sequencer #(.N(N)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .pause       (pause),
        .abort       (abort),
        .auto_reload (auto_reload),
        .load_val    (load_val),
        .term_val    (term_val),
        .Q           (Q),
        .busy        (busy),
        .done        (done),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_q     = 0;
        m_done  = 0;
    endtask

    task automatic model_step(input int s, input int p, input int a, input int ar,
                              input int lv, input int tv);
        int ns;
        ns     = m_state;
        m_done = 0;
        if (m_state == 0) begin
            if (s != 0) ns = 1;
        end else if (a != 0) begin
            ns = 0;
        end else if (m_state == 1) begin
            m_q = lv;
            ns  = 2;
        end else if (m_state == 3) begin
            ns = (p != 0) ? 3 : 2;
        end else if (p != 0) begin
            ns = 3;
        end else if (m_q == tv) begin
            m_done = 1;
            ns     = (ar != 0) ? 1 : 0;
        end else begin
            m_q = (m_q + 1) % M;
        end
        m_state = ns;
    endtask

    task automatic tick();
        int s, p, a, ar, lv, tv;
        s  = int'(start);
        p  = int'(pause);
        a  = int'(abort);
        ar = int'(auto_reload);
        lv = int'(load_val);
        tv = int'(term_val);
        @(posedge clk);
        #1;
        model_step(s, p, a, ar, lv, tv);
        if (done === 1'b1) done_count++;
        check("q",     32'(Q),     32'(m_q));
        check("state", 32'(state), 32'(m_state));
        check("done",  32'(done),  32'(m_done));
        check("busy",  32'(busy),  32'(m_state != 0));
    endtask

    task automatic run_oneshot(input string tag, input int lv, input int tv);
        int q_seq[$];
        int edges;
        int d;
        bit got;
        load_val    = N'(lv);
        term_val    = N'(tv);
        auto_reload = 1'b0;
        pause       = 1'b0;
        abort       = 1'b0;
        start       = 1'b1;
        tick();
        start = 1'b0;
        edges = 0;
        got   = 1'b0;
        d     = (tv - lv + M) % M;
        for (int i = 0; i < M + 8 && !got; i++) begin
            tick();
            edges++;
            if (state == 2'd2) q_seq.push_back(int'(Q));
            if (done === 1'b1) got = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(edges), 32'(2 + d));
        check({tag, "_seq_len"}, 32'(q_seq.size()), 32'(d + 1));
        for (int k = 0; k < q_seq.size() && k <= d; k++) begin
            check({tag, "_seq"}, 32'(q_seq[k]), 32'((lv + k) % M));
        end
        check({tag, "_final_q"}, 32'(Q), 32'(tv));
        check({tag, "_final_busy"}, 32'(busy), 32'd0);
        tick();
        check({tag, "_done_once"}, 32'(done), 32'd0);
    endtask

    initial begin
        clr         = 1'b0;
        start       = 1'b0;
        pause       = 1'b0;
        abort       = 1'b0;
        auto_reload = 1'b0;
        load_val    = '0;
        term_val    = '0;
        model_reset();

        #2;
        check("rst_q",     32'(Q),     32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        @(negedge clk);
        clr = 1'b1;
        tick();

        run_oneshot("os_2_5", 2, 5);
        run_oneshot("os_14_1", 14, 1);
        run_oneshot("os_9_9", 9, 9);

        // Pause for three cycles while Q=1.
        done_count  = 0;
        load_val    = N'(0);
        term_val    = N'(3);
        start       = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pause_pre_q", 32'(Q), 32'd1);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pause_hold_state", 32'(state), 32'd3);
            check("pause_hold_q", 32'(Q), 32'd1);
        end
        pause = 1'b0;
        for (int i = 0; i < 12 && busy; i++) tick();
        check("pause_busy_end", 32'(busy), 32'd0);
        check("pause_done_count", 32'(done_count), 32'd1);
        check("pause_final_q", 32'(Q), 32'd3);

        // Auto-reload 6..7, then abort.
        done_count  = 0;
        auto_reload = 1'b1;
        load_val    = N'(6);
        term_val    = N'(7);
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("ar_done_count", 32'(done_count), 32'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ar_abort_state", 32'(state), 32'd0);
        done_count = 0;
        for (int i = 0; i < 5; i++) tick();
        check("ar_no_more_done", 32'(done_count), 32'd0);
        auto_reload = 1'b0;

        // Asynchronous clear mid-RUN at Q=3; start during RUN ignored.
        load_val = N'(0);
        term_val = N'(10);
        start    = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        check("clr_pre_q", 32'(Q), 32'd3);
        check("clr_pre_state", 32'(state), 32'd2);
        #2;
        clr = 1'b0;
        #1;
        model_reset();
        check("clr_async_q",     32'(Q),     32'd0);
        check("clr_async_state", 32'(state), 32'd0);
        check("clr_async_done",  32'(done),  32'd0);
        start = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("clr_wait_idle", 32'(state), 32'd0);

        // Randomized phase against the reference.
        for (int i = 0; i < 400; i++) begin
            start       = 1'($urandom_range(0, 1));
            pause       = 1'($urandom_range(0, 3) == 0);
            abort       = 1'($urandom_range(0, 15) == 0);
            auto_reload = 1'($urandom_range(0, 1));
            load_val    = N'($urandom_range(0, M - 1));
            term_val    = N'($urandom_range(0, M - 1));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter: N, 4, counter width in bits (N >= 2).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 clr  input  1  asynchronous active-low reset.
REQ-004 start  input  1  begin a count sequence; sampled only in IDLE.
REQ-005 pause  input  1  level; freezes counting while high.
REQ-006 abort  input  1  level; terminates any active sequence.
REQ-007 auto_reload  input  1  level; selects restart-on-terminal versus one-shot.
REQ-008 load_val  input  N  start value of a sequence.
REQ-009 term_val  input  N  terminal value of a sequence.
REQ-010 Q  output  N  registered count value.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 done  output  1  registered one-cycle pulse on terminal count.
REQ-013 state  output  2  current state encoding: IDLE=0, LOAD=1, RUN=2, HOLD=3.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, LOAD, RUN and HOLD.
REQ-015 IDLE: Q holds its value; start=1 at an edge -> LOAD.
REQ-016 start SHALL be ignored in every state other than IDLE.
REQ-017 LOAD: at the edge, Q <= load_val (sampled at that edge) and the state goes to RUN.
REQ-018 RUN with pause=0 and Q!=term_val: Q <= Q+1 modulo 2^N (wraps from all-ones to 0).
REQ-019 RUN with pause=0 and Q==term_val: Q holds, done <= 1 for exactly one cycle, and the state goes to LOAD if auto_reload=1, else to IDLE.
REQ-020 RUN with pause=1: Q holds and the state goes to HOLD; terminal detection is suppressed that cycle.
REQ-021 HOLD: Q holds; pause=0 -> RUN; pause=1 -> stay in HOLD.
REQ-022 abort=1 in LOAD, RUN or HOLD: the state goes to IDLE at the next edge, Q holds, and no done pulse is produced.
REQ-023 Priority within one cycle SHALL be abort > pause > terminal compare > increment.
REQ-024 done SHALL be 0 in every cycle other than the one following a terminal detection.
REQ-025 busy SHALL be decoded combinationally from the state register only.
REQ-026 load_val==term_val: done SHALL assert one cycle after the first RUN cycle.
REQ-027 load_val > term_val: counting SHALL wrap through 2^N-1 to 0 and reach term_val.
REQ-028 Latency for one-shot mode: start sampled at edge t0 -> Q=load_val after t1 -> done high after edge t0+2+(term_val-load_val mod 2^N), with no pause cycles.
REQ-029 auto_reload SHALL be sampled at the terminal edge only.

Reset
REQ-030 clr=0 SHALL immediately force state=IDLE, Q=0 and done=0, independent of clk.
REQ-031 Reset asserted mid-sequence SHALL abandon the sequence with no done pulse; after release the block SHALL wait in IDLE for start.
REQ-032 All registers SHALL be reset asynchronously by clr; no synchronous clear path.

Structure
REQ-033 State encodings (IDLE/LOAD/RUN/HOLD) and the default width SHALL live in a shared package counter_ctrl_pkg.
REQ-034 The N-bit register with load, increment-enable and hold SHALL be a sub-module load_counter, with ports clr, clk, load, en, d and Q; the FSM SHALL stay in counter_sequencer.
REQ-035 load_counter SHALL use no arithmetic other than the +1 increment.

Verification
REQ-036 N=4, load_val=2, term_val=5, auto_reload=0, pulse start -> Q sequence 2,3,4,5; one done pulse; return to IDLE with Q=5 and busy=0.
REQ-037 load_val=14, term_val=1 -> Q sequence 14,15,0,1; done once.
REQ-038 load_val=0, term_val=3, pause high for 3 cycles when Q=1 -> Q stays at 1 for those cycles (state=HOLD), then 2,3; done once.
REQ-039 auto_reload=1, load_val=6, term_val=7 -> Q sequence 6,7,6,7,...; a done pulse at every terminal; abort=1 -> IDLE with no further done.
REQ-040 clr driven low mid-RUN at Q=3 -> Q=0, state=IDLE and done=0 without a clock edge; start pulses during RUN are ignored.
REQ-041 load_val=term_val=9 -> done one cycle after the first RUN cycle; Q=9 throughout.
